// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel frame controller.
package sobel_pkg;

    localparam int unsigned PIX_CHANNELS = 1;
    localparam int unsigned PIX_W        = PIX_CHANNELS * 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    // Pixels in one frame.
    function automatic int unsigned frame_pixels(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

endpackage

// File: rtl/sobel_raster_cnt.sv
// Column/row raster counter with clear, enable and end-of-frame flag.
module sobel_raster_cnt #(
    parameter int unsigned WIDTH_P  = 640,
    parameter int unsigned HEIGHT_P = 480
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_pixel_c
);

    localparam int unsigned COL_W = (WIDTH_P  > 1) ? $clog2(WIDTH_P)  : 1;
    localparam int unsigned ROW_W = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH_P - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT_P - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;

    assign col_last     = (col == COL_MAX);
    assign row_last     = (row == ROW_MAX);
    assign last_pixel_c = col_last & row_last;

    // Advance the raster position on each accepted pixel, wrapping at line and frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around sobel_pipeline: admits one frame per start, counts
// returned pixels, checks the last flag and reports done/error.
// Optional statistics counters are built when SOBEL_FRAME_STATS_EN is defined.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P    = 640,
    parameter int unsigned HEIGHT_P   = 480,
    parameter int unsigned CHANNELS_P = PIX_CHANNELS
`ifdef SOBEL_FRAME_STATS_EN
    ,
    parameter int unsigned STATS_W_P  = 32
`endif
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic                    src_valid_i,
    output logic                    src_ready_o,
    input  logic [CHANNELS_P*8-1:0] src_pixel_i,
    output logic                    feed_valid_o,
    input  logic                    feed_ready_i,
    output logic [CHANNELS_P*8-1:0] feed_pixel_o,
    input  logic                    ret_valid_i,
    output logic                    ret_ready_o,
    input  logic [CHANNELS_P*8-1:0] ret_pixel_i,
    input  logic                    ret_last_i,
    output logic                    sink_valid_o,
    input  logic                    sink_ready_i,
    output logic [CHANNELS_P*8-1:0] sink_pixel_o,
    output logic                    sink_sof_o,
    output logic                    sink_last_o
`ifdef SOBEL_FRAME_STATS_EN
    ,
    output logic [STATS_W_P-1:0]    cycles_o,
    output logic [STATS_W_P-1:0]    stall_in_o,
    output logic [STATS_W_P-1:0]    stall_out_o
`endif
);

    localparam int unsigned FRAME_PIX = frame_pixels(WIDTH_P, HEIGHT_P);
    localparam int unsigned CNT_W     = $clog2(FRAME_PIX) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_PIX);

    ctrl_state_e      state;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             last_seen;
    logic [CNT_W-1:0] out_cnt;

    logic in_feed;
    logic counting;
    logic feed_hs;
    logic ret_hs;
    logic ret_last_hs;
    logic start_acc;
    logic err_evt;
    logic last_pixel_c;

    assign in_feed     = (state == FEED);
    assign counting    = (state == FEED) || (state == DRAIN);
    assign start_acc   = (state == IDLE) && start_i;

    assign feed_valid_o = in_feed & src_valid_i;
    assign src_ready_o  = in_feed & feed_ready_i;
    assign feed_pixel_o = src_pixel_i;

    assign sink_valid_o = ret_valid_i;
    assign ret_ready_o  = sink_ready_i;
    assign sink_pixel_o = ret_pixel_i;
    assign sink_last_o  = ret_last_i;
    assign sink_sof_o   = counting && (out_cnt == '0);

    assign feed_hs     = feed_valid_o & feed_ready_i;
    assign ret_hs      = ret_valid_i & sink_ready_i;
    assign ret_last_hs = ret_hs & ret_last_i;

    // Stray beats in IDLE, wrong last position, or beats past the frame end are errors.
    assign err_evt = (state == IDLE) ? ret_hs
                   : ((ret_last_hs && (out_cnt != LAST_CNT)) || (ret_hs && (out_cnt == FULL_CNT)));

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    sobel_raster_cnt #(
        .WIDTH_P  (WIDTH_P),
        .HEIGHT_P (HEIGHT_P)
    ) u_raster (
        .clk          (clk_i),
        .rst          (reset_i),
        .clr          (start_acc),
        .en           (feed_hs),
        .last_pixel_c (last_pixel_c)
    );

    // Frame sequencer with registered busy/done and early-last tracking.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= FEED;
                        busy_q    <= 1'b1;
                        last_seen <= 1'b0;
                    end
                end
                FEED: begin
                    if (ret_last_hs) begin
                        last_seen <= 1'b1;
                    end
                    if (feed_hs && last_pixel_c) begin
                        if (last_seen || ret_last_hs) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ret_last_hs) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Returned-pixel counter; holds at the frame size so overruns stay detectable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_cnt <= '0;
        end else if (start_acc) begin
            out_cnt <= '0;
        end else if (counting && ret_hs && (out_cnt != FULL_CNT)) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end

    // Sticky error flag, cleared by an accepted start; a same-cycle error still sets it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_evt | (err_q & ~start_acc);
        end
    end

`ifdef SOBEL_FRAME_STATS_EN
    localparam logic [STATS_W_P-1:0] STATS_MAX = '1;

    // Saturating per-frame activity and stall counters.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cycles_o    <= '0;
            stall_in_o  <= '0;
            stall_out_o <= '0;
        end else if (start_acc) begin
            cycles_o    <= '0;
            stall_in_o  <= '0;
            stall_out_o <= '0;
        end else begin
            if (counting && (cycles_o != STATS_MAX)) begin
                cycles_o <= cycles_o + STATS_W_P'(1);
            end
            if (in_feed && src_valid_i && !feed_ready_i && (stall_in_o != STATS_MAX)) begin
                stall_in_o <= stall_in_o + STATS_W_P'(1);
            end
            if (busy_q && ret_valid_i && !sink_ready_i && (stall_out_o != STATS_MAX)) begin
                stall_out_o <= stall_out_o + STATS_W_P'(1);
            end
        end
    end
`endif

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
- Frame-level sequencer that sits around sobel_pipeline.
- Admits exactly one WIDTH_P x HEIGHT_P frame from an upstream pixel source into the pipeline per start command.
- Tracks the raster position of the input and counts returned pixels. Checks the pipeline's last flag against the expected pixel count, then signals frame completion and error status to the host.

Parameters:
- WIDTH_P, 640, frame width in pixels
- HEIGHT_P, 480, frame height in pixels
- CHANNELS_P, 1, bytes per pixel; pixel bus width is CHANNELS_P*8
- STATS_W_P, 32, width of the statistics counters (FRAME_STATS_EN only)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- start_i  in  1  start-frame request, one-cycle pulse
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle frame-complete pulse
- err_o  out  1  sticky frame error
- src_valid_i  in  1  upstream pixel valid
- src_ready_o  out  1  upstream pixel ready
- src_pixel_i  in  CHANNELS_P*8  upstream pixel
- feed_valid_o  out  1  to pipeline valid_i
- feed_ready_i  in  1  from pipeline ready_o
- feed_pixel_o  out  CHANNELS_P*8  to pipeline pixel_i
- ret_valid_i  in  1  from pipeline valid_o
- ret_ready_o  out  1  to pipeline ready_i
- ret_pixel_i  in  CHANNELS_P*8  from pipeline pixel_o
- ret_last_i  in  1  from pipeline last_o
- sink_valid_o  out  1  downstream pixel valid
- sink_ready_i  in  1  downstream ready
- sink_pixel_o  out  CHANNELS_P*8  downstream pixel
- sink_sof_o  out  1  first output pixel of the frame
- sink_last_o  out  1  last output pixel of the frame

Behaviour:
- Reset: state IDLE; col, row and out_cnt = 0; busy_o=0, done_o=0, err_o=0.
- Reset can assert mid-frame. It aborts to IDLE immediately; partial frame state is discarded.
- States and transitions:
  - IDLE: start_i -> FEED. On this transition col, row, out_cnt and last_seen are cleared and err_o is cleared.
  - FEED: handshake on the final input pixel (col=WIDTH_P-1, row=HEIGHT_P-1): go to DRAIN; if last_seen=1, go directly to DONE.
  - DRAIN: return handshake with ret_last_i=1 -> DONE.
  - DONE: exactly one cycle, done_o=1 -> IDLE.
  - busy_o=1 in FEED, DRAIN and DONE. start_i outside IDLE is ignored.
- Input path:
  - In FEED: feed_valid_o=src_valid_i, src_ready_o=feed_ready_i, feed_pixel_o=src_pixel_i. All combinational, zero added latency.
  - In every other state: feed_valid_o=0 and src_ready_o=0.
  - A handshake (feed_valid_o&feed_ready_i) advances col. At col=WIDTH_P-1, col wraps to 0 and row increments.
- Return path, all states, combinational pass-through:
  - sink_valid_o=ret_valid_i, ret_ready_o=sink_ready_i, sink_pixel_o=ret_pixel_i, sink_last_o=ret_last_i.
- Output counting:
  - In FEED/DRAIN, each handshake increments out_cnt.
  - out_cnt width is $clog2(WIDTH_P*HEIGHT_P)+1.
  - sink_sof_o = (state FEED or DRAIN) & out_cnt==0.
- Error conditions; each sets err_o, which stays set until the next accepted start_i:
  - ret_last_i handshake with out_cnt != WIDTH_P*HEIGHT_P-1.
  - Return handshake with out_cnt == WIDTH_P*HEIGHT_P, i.e. overrun.
  - Any return handshake while IDLE, i.e. a stray beat.
- Early last: ret_last_i handshake in FEED sets last_seen (and err_o, per the count rule). The frame then ends when input completes.
- Simultaneous final input handshake and ret_last handshake in FEED: go to DONE.

Optional Feature:
- Macro SOBEL_FRAME_STATS_EN.
- When defined, adds outputs cycles_o, stall_in_o and stall_out_o, each STATS_W_P wide.
- cycles_o counts the cycles in FEED+DRAIN.
- stall_in_o counts FEED cycles with src_valid_i&~feed_ready_i.
- stall_out_o counts cycles with ret_valid_i&~sink_ready_i while busy.
- All three clear on accepted start_i, hold after DONE, and saturate at their maximum.
- When not defined, the ports and logic are absent.

Decomposition:
- Package sobel_pkg holds:
  - state enum typedef ctrl_state_e {IDLE, FEED, DRAIN, DONE}
  - pixel_t typedef, sized from CHANNELS_P
  - localparam function for the frame pixel count
- One natural sub-module, sobel_raster_cnt: col/row counter with enable, clear, wrap, and a last_pixel flag.

Test Plan:
- Use WIDTH_P=8, HEIGHT_P=4 for all scenarios.
- Nominal: start, stream 32 pixels with ready held high, model returns 32 with last on beat 32 -> done_o pulses one cycle, err_o=0, sink_sof_o on beat 1 only.
- Backpressure: feed_ready_i toggles 50% and sink_ready_i deasserts for 5 cycles -> no pixel lost or duplicated, exactly 32 input handshakes, src_ready_o=0 after the 32nd.
- Short frame: model asserts last on beat 30 -> err_o=1, done_o pulses; the next start clears err_o.
- Stray: return beat while IDLE -> err_o=1; start_i during FEED -> ignored, counters unchanged.
- Reset mid-frame: reset_i asserted after 10 inputs -> busy_o=0 immediately; the next frame of 32 completes cleanly.
- SOBEL_FRAME_STATS_EN: 3 injected input stall cycles -> stall_in_o=3, cycles_o equals the measured FEED+DRAIN duration.
